pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the 5-stage MIPS32 core. It arbitrates stall requests from the decode stage (load-use hazards on register reads) and from the execute stage (multi-cycle operations) into a single per-stage stall vector. It also sequences exception/branch-target flushes and supervises stall run length with a watchdog. It sits beside the pipeline registers (pc_reg, if_id, id_ex, ex_mem, mem_wb), which all consume its stall vector and flush pulse.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_sat_counter.sv | 34 +++
 rtl/pipe_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stage indices,
// stall vector constants and FSM state codes.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // An EX stall freezes everything up to and including EX; an ID stall only the front end.
    localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{NoStop}};
    localparam logic [STALL_W-1:0] STALL_EX   = {NoStop, NoStop, Stop, Stop, Stop, Stop};
    localparam logic [STALL_W-1:0] STALL_ID   = {NoStop, NoStop, NoStop, Stop, Stop, Stop};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    function automatic logic [STALL_W-1:0] stallVector(input logic reqId, input logic reqEx);
        if (reqEx)
            return STALL_EX;
        else if (reqId)
            return STALL_ID;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the stall run
// length and the optional performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && (count_q < max_i))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with stall-run watchdog.
// Optional feature macro: STALL_PERF_EN (stall-cycle and flush performance counters).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_CYC = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             flush_req_i,
    input  logic [31:0]      new_pc_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             wdog_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    state_e       state_q;
    logic         flush_q;
    logic [31:0]  new_pc_q;
    logic         wdog_q;
    logic         wdog_d;
    logic [5:0]   stall_d;
    logic         stalled;
    logic [15:0]  runCnt;

    // Stall vector is combinational so a load-use stall takes effect in the cycle it is raised.
    always_comb begin
        stall_d = STALL_NONE;
        if (state_q != ST_FLUSH)
            stall_d = stallVector(stallreq_id_i, stallreq_ex_i);
    end

    assign stalled = |stall_d;
    assign wdog_d  = stalled && (runCnt == 16'(WDOG_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            new_pc_q <= ZeroWord;
            wdog_q   <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            if (flush_req_i) begin
                state_q  <= ST_FLUSH;
                flush_q  <= 1'b1;
                new_pc_q <= new_pc_i;
            end else if (stallreq_id_i || stallreq_ex_i) begin
                state_q <= ST_STALL;
                flush_q <= 1'b0;
            end else begin
                state_q <= ST_RUN;
                flush_q <= 1'b0;
            end
        end
    end

    sat_counter #(.W(16)) u_run_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stalled),
        .clr_i   (!stalled),
        .max_i   (16'(WDOG_CYC)),
        .count_o (runCnt)
    );

`ifdef STALL_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_perf (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stalled),
        .clr_i   (1'b0),
        .max_i   ({CNT_W{1'b1}}),
        .count_o (stall_cycles_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_perf (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush_q),
        .clr_i   (1'b0),
        .max_i   ({CNT_W{1'b1}}),
        .count_o (flush_count_o)
    );
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

    assign stall_o  = stall_d;
    assign flush_o  = flush_q;
    assign new_pc_o = new_pc_q;
    assign wdog_o   = wdog_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: vector table plus watchdog and
// asynchronous-reset sequences.
module tb_pipe_ctrl;

    localparam int WDOG_CYC = 64;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_id_i;
    logic             stallreq_ex_i;
    logic             flush_req_i;
    logic [31:0]      new_pc_i;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic             wdog_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] flush_count_o;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic        id;
        logic        ex;
        logic        fl;
        logic [31:0] pc;
        logic [5:0]  expStall;
        logic        expFlush;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[15];

    pipe_ctrl #(.WDOG_CYC(WDOG_CYC), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .flush_req_i    (flush_req_i),
        .new_pc_i       (new_pc_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .wdog_o         (wdog_o),
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic id, input logic ex, input logic fl, input logic [31:0] pc);
        @(posedge clk);
        #1;
        stallreq_id_i = id;
        stallreq_ex_i = ex;
        flush_req_i   = fl;
        new_pc_i      = pc;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] expStall, input logic expFlush,
                               input logic [31:0] expPc, input logic expWdog);
        vecCount++;
        if (stall_o !== expStall || flush_o !== expFlush || new_pc_o !== expPc || wdog_o !== expWdog) begin
            missCount++;
            $display("[TB] FAIL %s: got stall=%b flush=%b pc=%h wdog=%b, expected stall=%b flush=%b pc=%h wdog=%b",
                     name, stall_o, flush_o, new_pc_o, wdog_o, expStall, expFlush, expPc, expWdog);
        end
    endtask

    task automatic checkCounters(input string name, input logic [CNT_W-1:0] expStallCyc,
                                 input logic [CNT_W-1:0] expFlushCnt);
        vecCount++;
        if (stall_cycles_o !== expStallCyc || flush_count_o !== expFlushCnt) begin
            missCount++;
            $display("[TB] FAIL %s: got stall_cycles=%0d flush_count=%0d, expected stall_cycles=%0d flush_count=%0d",
                     name, stall_cycles_o, flush_count_o, expStallCyc, expFlushCnt);
        end
    endtask

    task automatic setVec(input int i, input logic id, input logic ex, input logic fl, input logic [31:0] pc,
                          input logic [5:0] expStall, input logic expFlush, input logic [31:0] expPc);
        vecs[i].id       = id;
        vecs[i].ex       = ex;
        vecs[i].fl       = fl;
        vecs[i].pc       = pc;
        vecs[i].expStall = expStall;
        vecs[i].expFlush = expFlush;
        vecs[i].expPc    = expPc;
    endtask

    task automatic wdogRun(input string tag);
        for (int k = 1; k <= 70; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("%s_cyc%0d", tag, k), 6'b001111, 1'b0, 32'h0000_00c0, (k == 65));
        end
    endtask

    initial begin
        // Inputs (id, ex, flush, pc) and expected (stall, flush, new_pc) per cycle.
        setVec( 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0);
        setVec( 1, 1, 0, 0, 32'h0,   6'b000111, 0, 32'h0);
        setVec( 2, 1, 0, 0, 32'h0,   6'b000111, 0, 32'h0);
        setVec( 3, 1, 0, 0, 32'h0,   6'b000111, 0, 32'h0);
        setVec( 4, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0);
        setVec( 5, 1, 1, 0, 32'h0,   6'b001111, 0, 32'h0);
        setVec( 6, 0, 1, 0, 32'h0,   6'b001111, 0, 32'h0);
        setVec( 7, 0, 1, 1, 32'h40,  6'b001111, 0, 32'h0);
        setVec( 8, 0, 1, 0, 32'h0,   6'b000000, 1, 32'h40);
        setVec( 9, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h40);
        setVec(10, 1, 0, 0, 32'h0,   6'b000111, 0, 32'h40);
        setVec(11, 0, 0, 1, 32'h80,  6'b000000, 0, 32'h40);
        setVec(12, 0, 0, 1, 32'hc0,  6'b000000, 1, 32'h80);
        setVec(13, 0, 0, 0, 32'h0,   6'b000000, 1, 32'hc0);
        setVec(14, 0, 0, 0, 32'h0,   6'b000000, 0, 32'hc0);

        rst           = 1'b1;
        stallreq_id_i = 1'b0;
        stallreq_ex_i = 1'b0;
        flush_req_i   = 1'b0;
        new_pc_i      = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("idle%0d", i), 6'b000000, 1'b0, 32'h0, 1'b0);
        end
        checkCounters("idle_counters", '0, '0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].id, vecs[i].ex, vecs[i].fl, vecs[i].pc);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expFlush, vecs[i].expPc, 1'b0);
        end
`ifdef STALL_PERF_EN
        checkCounters("perf_after_table", 32'd7, 32'd3);
`else
        checkCounters("perf_after_table", '0, '0);
`endif

        wdogRun("wdogA");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("wdog_drop", 6'b000000, 1'b0, 32'h0000_00c0, 1'b0);
        wdogRun("wdogB");

        // Asynchronous reset landing in the middle of a FLUSH cycle.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0123);
        @(posedge clk);
        #3;
        stallreq_id_i = 1'b0;
        stallreq_ex_i = 1'b0;
        flush_req_i   = 1'b0;
        new_pc_i      = 32'h0;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_flush", 6'b000000, 1'b0, 32'h0, 1'b0);
        checkCounters("rst_mid_flush_counters", '0, '0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("post_rst_run", 6'b000111, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
